// File: rtl/alu_share_ctrl.sv
// Two-requester shared bitwise ALU with a round-robin grant and a response handshake.
// Each accepted operation occupies the unit for IDLE -> EXEC -> RESP before the next grant.
//
// state | meaning
// IDLE  | arbitrate pending requests, pulse ready to the winner
// EXEC  | compute the latched operation into the result register
// RESP  | hold the result on rsp_* until the consumer takes it
module alu_share_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    input  logic             rsp_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic             id_q, id_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             gnt0, gnt1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            op_q    <= 2'b00;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        case (state_q)
            IDLE: begin
                // rst_n gates the grant so ready stays low while reset is held.
                if (rst_n) begin
                    if (req0_valid && (!req1_valid || last_q)) begin
                        gnt0 = 1'b1;
                    end else if (req1_valid) begin
                        gnt1 = 1'b1;
                    end
                end
                if (gnt0 || gnt1) begin
                    state_d = EXEC;
                    id_d    = gnt1;
                    last_d  = gnt1;
                    op_d    = gnt1 ? req1_op : req0_op;
                    a_d     = gnt1 ? req1_a  : req0_a;
                    b_d     = gnt1 ? req1_b  : req0_b;
                end
            end
            EXEC: begin
                case (op_q)
                    2'b00:   res_d = a_q & b_q;
                    2'b01:   res_d = a_q | b_q;
                    2'b10:   res_d = a_q ^ b_q;
                    default: res_d = ~(a_q | b_q);
                endcase
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign rsp_valid  = (state_q == RESP);
    assign rsp_id     = id_q;
    assign rsp_data   = res_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: doc/alu_share_ctrl.md
ALU_SHARE_CTRL -- requirements
Module: alu_share_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand and result width in bits.
REQ-002 SHALL have port clk, input, 1: single rising-edge clock for all state.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port req0_valid, input, 1: requester 0 has an operation pending.
REQ-005 SHALL have port req0_op, input, 2: requester 0 opcode (00 AND, 01 OR, 10 XOR, 11 NOR).
REQ-006 SHALL have ports req0_a and req0_b, input, WIDTH each: requester 0 operands.
REQ-007 SHALL have port req0_ready, output, 1: requester 0 operation accepted this cycle.
REQ-008 SHALL have ports req1_valid, req1_op, req1_a, req1_b and req1_ready, identical to REQ-004..REQ-007, for requester 1.
REQ-009 SHALL have port rsp_valid, output, 1: result available.
REQ-010 SHALL have port rsp_id, output, 1: index of the requester that owns the result.
REQ-011 SHALL have port rsp_data, output, WIDTH: bitwise result.
REQ-012 SHALL have port rsp_ready, input, 1: consumer accepts the result.
REQ-013 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-014 SHALL implement an FSM with states IDLE, EXEC and RESP.
REQ-015 IDLE: if either valid is high, SHALL grant exactly one requester, assert its ready combinationally in the same cycle, latch op/a/b/id at the clock edge, and move to EXEC.
REQ-016 SHALL drive at most one readyN high in any cycle, and SHALL drive both low outside IDLE.
REQ-017 Arbitration SHALL be round-robin: if only one valid is high, that requester wins; if both are high, the requester not granted last wins.
REQ-018 The last-grant pointer SHALL update only on an actual grant.
REQ-019 EXEC: SHALL compute the bitwise result of the latched operands per latched op into a result register, then move to RESP unconditionally.
REQ-020 The NOR result SHALL be the bitwise inverse of the OR; all ops are bitwise across WIDTH with no carries or flags.
REQ-021 RESP: SHALL drive rsp_valid high with rsp_id and rsp_data from registers, and move to IDLE at the edge where rsp_ready is high.
REQ-022 While rsp_valid is high and rsp_ready is low, rsp_valid, rsp_id and rsp_data SHALL remain stable.
REQ-023 Latency SHALL be fixed: a request accepted at edge N produces rsp_valid high in the cycle after edge N+1.
REQ-024 Minimum spacing between two accepted requests SHALL be 3 cycles, with one further cycle per stalled rsp_ready cycle.
REQ-025 A request arriving while busy SHALL be held off (ready low), never dropped, and evaluated in the next IDLE cycle.
REQ-026 rsp_ready asserted outside RESP SHALL have no effect.
REQ-027 Opcode and operand changes on the inputs after acceptance SHALL NOT affect the in-flight result.

Reset
REQ-028 Asserting rst_n low SHALL immediately force: state IDLE; rsp_valid 0; rsp_id 0; rsp_data 0; busy 0; req0_ready and req1_ready 0 until release; last-grant pointer set to 1, so requester 0 wins the first tie.
REQ-029 Reset during EXEC or RESP SHALL abort the operation with no response generated.
REQ-030 After rst_n rises, the first grant SHALL be possible in the first IDLE cycle.

Verification
REQ-031 Single request: req0 AND, a=16'hF0F0, b=16'hFF00, rsp_ready=1 -> req0_ready pulses 1 cycle; 2 cycles later rsp_valid=1, rsp_id=0, rsp_data=16'hF000, for 1 cycle.
REQ-032 Tie and fairness: both valid continuously, req0 XOR 16'hAAAA^16'h5555, req1 NOR 16'h0000,16'h0000 -> grants alternate 0,1,0,1; responses 16'hFFFF (id 0) and 16'hFFFF (id 1), spaced 3 cycles apart.
REQ-033 Backpressure: rsp_ready held low for 5 cycles in RESP -> rsp_valid/rsp_id/rsp_data stable for all 5 cycles; pending req1 ready stays low and is granted the cycle after release.
REQ-034 Operand change: req1 OR 16'h000F,16'h00F0 accepted, then inputs changed to 16'hFFFF -> rsp_data=16'h00FF.
REQ-035 Reset mid-operation: drop rst_n in EXEC -> rsp_valid 0 immediately, no response after release; the next tie grants requester 0.
